// File: rtl/ssd_scan_driver_pkg.sv
// Shared segment codes and limits for the 7-segment scan driver.
// Segment bit order is {g,f,e,d,c,b,a}, logical (1 = lit).
package ssd_scan_driver_pkg;

  localparam int SSD_MAX_DIGITS = 8;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h00;
  localparam seg_t SEG_0   = 7'h3F;
  localparam seg_t SEG_1   = 7'h06;
  localparam seg_t SEG_2   = 7'h5B;
  localparam seg_t SEG_3   = 7'h4F;
  localparam seg_t SEG_4   = 7'h66;
  localparam seg_t SEG_5   = 7'h6D;
  localparam seg_t SEG_6   = 7'h7D;
  localparam seg_t SEG_7   = 7'h07;
  localparam seg_t SEG_8   = 7'h7F;
  localparam seg_t SEG_9   = 7'h6F;
  localparam seg_t SEG_A   = 7'h77;
  localparam seg_t SEG_B   = 7'h7C;
  localparam seg_t SEG_C   = 7'h39;
  localparam seg_t SEG_D   = 7'h5E;
  localparam seg_t SEG_E   = 7'h79;
  localparam seg_t SEG_F   = 7'h71;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t code;
    case (nib)
      4'h0:    code = SEG_0;
      4'h1:    code = SEG_1;
      4'h2:    code = SEG_2;
      4'h3:    code = SEG_3;
      4'h4:    code = SEG_4;
      4'h5:    code = SEG_5;
      4'h6:    code = SEG_6;
      4'h7:    code = SEG_7;
      4'h8:    code = SEG_8;
      4'h9:    code = SEG_9;
      4'hA:    code = SEG_A;
      4'hB:    code = SEG_B;
      4'hC:    code = SEG_C;
      4'hD:    code = SEG_D;
      4'hE:    code = SEG_E;
      default: code = SEG_F;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Nibble to logical 7-segment code (1 = lit, {g,f,e,d,c,b,a}).
// Latency: combinational. Backpressure: none.
// No state; polarity is applied by the caller.
module ssd_hex_decode
  import ssd_scan_driver_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nib);

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver; optional SSD_LZ_BLANK_EN macro adds leading-zero suppression.
// Latency: seg/dp/an registered, one cycle after the digit index/prescaler state they reflect.
// Backpressure: none; en=0 freezes the scan and darkens all digits.
module ssd_scan_driver
  import ssd_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PS_LAST  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PS_BLANK = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_PIN_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_PIN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [PW-1:0]           pcnt;
  logic [IW-1:0]           idx;
  logic                    primed;
  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [NUM_DIGITS-1:0]   sh_lz;
  logic [NUM_DIGITS-1:0]   lz_next;

  logic slot_end;
  logic frame_end;
  logic capture;

  assign slot_end  = en && (pcnt == PS_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  // Shadow loads once per frame so a digit never shows a half-updated word.
  assign capture   = frame_end || !primed;

`ifdef SSD_LZ_BLANK_EN
  logic upper_zero;
  always_comb begin
    lz_next    = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero && (value[4*i +: 4] == 4'h0);
      lz_next[i] = upper_zero;
    end
  end
`else
  assign lz_next = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt     <= '0;
      idx      <= '0;
      primed   <= 1'b0;
      sh_val   <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      sh_lz    <= '0;
    end else begin
      primed <= 1'b1;
      if (en) begin
        pcnt <= slot_end ? '0 : pcnt + 1'b1;
      end
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (capture) begin
        sh_val   <= value;
        sh_dp    <= dp_in;
        sh_blank <= blank_in;
        sh_lz    <= lz_next;
      end
    end
  end

  logic [3:0]            cur_nib;
  logic [6:0]            cur_code;
  logic                  dig_dark;
  logic [6:0]            seg_log;
  logic                  dp_log;
  logic [NUM_DIGITS-1:0] an_log;

  assign cur_nib = sh_val[4*idx +: 4];

  ssd_hex_decode u_dec (
    .nib (cur_nib),
    .seg (cur_code)
  );

  // Leading-zero dark digits keep their decimal point; forced blanks do not.
  assign dig_dark = sh_blank[idx] | sh_lz[idx];
  assign seg_log  = dig_dark ? SEG_OFF : cur_code;
  assign dp_log   = sh_dp[idx] & ~sh_blank[idx];
  assign an_log   = (en && (pcnt >= PS_BLANK)) ? (NUM_DIGITS'(1) << idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_PIN_OFF;
      dp         <= SEG_ACTIVE_LOW;
      an         <= AN_PIN_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_log ^ SEG_PIN_OFF;
      dp         <= dp_log ^ SEG_ACTIVE_LOW;
      an         <= an_log ^ AN_PIN_OFF;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: directed phases plus random traffic against a time-based model.
module tb_ssd_scan_driver;

  localparam int N = 4;
  localparam int P = 8;
  localparam int B = 2;
`ifdef SSD_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  always #5 clk = ~clk;

  ssd_scan_driver #(
    .NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  int total = 0;
  int bad = 0;

  // Model: t = enabled cycles since reset; slot/digit/phase follow by division.
  int          t;
  bit          first;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_ft;
  logic [6:0]  codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic lz_dark(int d, logic [15:0] v);
    return LZ && (d > 0) && ((v >> (4 * d)) == 16'h0);
  endfunction

  task automatic check(string tag, logic [6:0] obs, logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, exp, t);
    end
  endtask

  task automatic step();
    int pos;
    int dig;
    logic [6:0] lit;
    @(posedge clk);
    if (!rst_n) begin
      t = 0; first = 1'b1; m_val = '0; m_dp = '0; m_blank = '0;
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_ft = 1'b0;
    end else begin
      pos = t % P;
      dig = (t / P) % N;
      lit = (m_blank[dig] || lz_dark(dig, m_val)) ? 7'h00 : codes[m_val[4*dig +: 4]];
      e_seg = ~lit;
      e_dp  = ~(m_dp[dig] & ~m_blank[dig]);
      e_an  = (en && pos >= B) ? ~(4'b0001 << dig) : 4'hF;
      e_ft  = en && (pos == P - 1) && (dig == N - 1);
      if (first || e_ft) begin
        m_val = value; m_dp = dp_in; m_blank = blank_in;
      end
      first = 1'b0;
      if (en) t++;
    end
    @(negedge clk);
    check("seg", seg, e_seg);
    check("dp", {6'b0, dp}, {6'b0, e_dp});
    check("an", {3'b0, an}, {3'b0, e_an});
    check("frame_tick", {6'b0, frame_tick}, {6'b0, e_ft});
  endtask

  initial begin
    // Reset held, then scan 1234.
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1; en = 1'b1; value = 16'h1234;
    repeat (2 * P * N) step();

    // Mid-frame value change while digit 1 is up.
    for (int k = 0; k < 4 * P * N; k++) begin
      if (((t / P) % N) == 1 && (t % P) == 3) break;
      step();
    end
    value = 16'hABCD;
    repeat (2 * P * N) step();

    // Forced blank and decimal point.
    blank_in = 4'b0100; dp_in = 4'b0001;
    repeat (2 * P * N) step();

    // Enable freeze mid-slot.
    for (int k = 0; k < 2 * P; k++) begin
      if ((t % P) == 4) break;
      step();
    end
    en = 1'b0;
    repeat (20) step();
    en = 1'b1;
    repeat (2 * P * N) step();

    // Leading-zero patterns.
    blank_in = '0; dp_in = 4'b1000; value = 16'h0070;
    repeat (2 * P * N) step();
    value = 16'h0000;
    repeat (2 * P * N) step();

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        value    = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
        dp_in    = 4'($urandom);
        blank_in = 4'($urandom) & 4'($urandom);
      end
      en = ($urandom_range(0, 9) != 0);
      step();
    end

    // Asynchronous reset mid-slot: outputs go off before any clock edge.
    en = 1'b1;
    for (int k = 0; k < 2 * P; k++) begin
      if ((t % P) == 5) break;
      step();
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", {6'b0, dp}, 7'h01);
    check("rst_an", {3'b0, an}, 7'h0F);
    check("rst_ft", {6'b0, frame_tick}, 7'h00);
    repeat (2) step();
    rst_n = 1'b1; value = 16'h1234; dp_in = '0; blank_in = '0;
    repeat (P * N + 4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
